adain_channel_seq: RTL
======================

// Module: adain_channel_seq
// PURPOSE
//   Channel-level scheduler for the AdaIN control unit. For each of num_ch channels it
//   fetches style params (handshake), runs the statistics pass (cu_start=2'b01), then the
//   normalize pass (cu_start=2'b10), and repeats. Watchdog resets a hung CU.
//   Sits between the layer controller (go/job_done) and cu_adain (start/N/done/state).
// PARAMETERS
//   C_MAX  512  max channels per job; CW = $clog2(C_MAX+1)
//   N_MAX  128  max feature-map side; NW = $clog2(N_MAX+1)
//   TO_W   20   watchdog width; timeout when counter reaches 2**TO_W-1
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous, active-high reset
//   go         in   1    job start pulse; sampled only in IDLE
//   num_ch     in   CW   channels in job, latched on go
//   n_in       in   NW   map side N, latched on go
//   style_ack  in   1    gamma/beta for ch_idx loaded
//   cu_state   in   3    CU FSM state (0 = IDLE)
//   cu_done    in   2    CU done code (1 = stats done, 2 = norm done)
//   cu_start   out  2    one-cycle start code to CU
//   cu_N       out  NW   latched N, held stable for the whole job
//   cu_rst     out  1    one-cycle CU reset on watchdog timeout
//   style_req  out  1    request style params for ch_idx
//   ch_idx     out  CW   current channel, 0..num_ch-1
//   phase      out  2    0 idle/style, 1 stats, 2 norm (for buffer muxing)
//   busy       out  1    high from the cycle after go until job_done
//   job_done   out  1    one-cycle pulse at job end
//   err        out  1    sticky timeout flag; cleared on accepted go
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, watchdog 0. rst mid-job aborts immediately.
//     No job_done. Caller must also reset CU.
//   All outputs registered. States: IDLE, STYLE, S_ISSUE, S_ARM, S_WAIT, N_ISSUE,
//     N_ARM, N_WAIT, NEXT, FINISH.
//   IDLE: go=1 -> latch num_ch/n_in, ch_idx=0, clear err, busy=1.
//     num_ch==0 -> FINISH. Else -> STYLE. go while busy ignored.
//   STYLE: style_req=1 until style_ack sampled high, then style_req=0 -> S_ISSUE.
//     ack in the same cycle req rises is valid. ack while req=0 is ignored.
//   S_ISSUE: cu_start=2'b01 for exactly 1 cycle, phase=1 -> S_ARM.
//   S_ARM: one blanking cycle. cu_done/cu_state ignored, since CU clears its stale done
//     on leaving IDLE -> S_WAIT.
//   S_WAIT: cu_state==0 && cu_done==1 -> N_ISSUE.
//   N_ISSUE: cu_start=2'b10 for 1 cycle, phase=2 -> N_ARM (blank 1 cycle) -> N_WAIT.
//   N_WAIT: cu_state==0 && cu_done==2 -> NEXT. Per-pixel done=2 while cu_state!=0 is
//     ignored.
//   NEXT: ch_idx==num_ch-1 -> FINISH. Else ch_idx+1, phase=0 -> STYLE.
//   FINISH: job_done=1 (1 cycle), busy=0, phase=0 -> IDLE.
//     Next go accepted the cycle after FINISH.
//   Watchdog: clears on every state change. Increments in STYLE, S_WAIT and N_WAIT.
//     On reaching 2**TO_W-1 -> err=1, cu_rst=1 (1 cycle), style_req=0 -> FINISH.
//     job_done still pulses.
//   Latency go -> style_req = 1 cycle. style_ack -> cu_start=01 = 2 cycles.
//     CU stats-done -> cu_start=10 = 2 cycles.
//   Widths: ch_idx compares against num_ch-1 in CW bits. num_ch = C_MAX is legal.
//     cu_N never changes while busy.
// TESTING
//   T1 num_ch=3, N=4, ack 1 cycle after req, CU model -> start seq 01,10 x3; ch_idx 0,1,2;
//      one job_done; err=0.
//   T2 num_ch=0, go -> job_done 2 cycles after go; no cu_start, no style_req.
//   T3 CU holds stale done=1 from the previous job at go -> S_ARM blanking, so no early
//      advance; norm issued only after the new stats done.
//   T4 CU emits done=2 per pixel with cu_state=6 -> no NEXT until cu_state=0.
//      C_MAX channel count wraps cleanly.
//   T5 TO_W=4, CU never returns to IDLE -> err=1, cu_rst pulse at 15 cycles in S_WAIT,
//      job_done; next go clears err.
//   T6 rst asserted in N_WAIT with ch_idx=1 -> next cycle all outputs 0, IDLE; go while
//      busy ignored.

Source files
------------

// File: rtl/adain_channel_seq.sv
// Channel scheduler for the AdaIN control unit: per channel it fetches style params,
// runs the CU statistics pass then the normalize pass, with a watchdog on a hung CU.
module adain_channel_seq #(
  parameter  int C_MAX = 512,
  parameter  int N_MAX = 128,
  parameter  int TO_W  = 20,
  localparam int CW    = $clog2(C_MAX + 1),
  localparam int NW    = $clog2(N_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [CW-1:0] num_ch,
  input  logic [NW-1:0] n_in,
  input  logic          style_ack,
  input  logic [2:0]    cu_state,
  input  logic [1:0]    cu_done,
  output logic [1:0]    cu_start,
  output logic [NW-1:0] cu_N,
  output logic          cu_rst,
  output logic          style_req,
  output logic [CW-1:0] ch_idx,
  output logic [1:0]    phase,
  output logic          busy,
  output logic          job_done,
  output logic          err
);

  typedef enum logic [3:0] {
    IDLE, STYLE, S_ISSUE, S_ARM, S_WAIT, N_ISSUE, N_ARM, N_WAIT, NEXT, FINISH
  } state_t;

  localparam logic [1:0] START_STATS = 2'b01;
  localparam logic [1:0] START_NORM  = 2'b10;
  localparam logic [1:0] DONE_STATS  = 2'd1;
  localparam logic [1:0] DONE_NORM   = 2'd2;
  // The counter is one step short of all-ones here; the next increment would reach it.
  localparam logic [TO_W-1:0] WD_TRIP = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state_q, state_d;
  logic [CW-1:0]   num_q, num_d;
  logic [NW-1:0]   n_q, n_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [1:0]      phase_q, phase_d;
  logic [1:0]      start_q, start_d;
  logic            cu_rst_q, cu_rst_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            wd_run, wd_tmo, cu_idle;

  assign cu_idle = (cu_state == 3'd0);
  assign wd_run  = (state_q == STYLE) || (state_q == S_WAIT) || (state_q == N_WAIT);
  assign wd_tmo  = wd_run && (wd_q == WD_TRIP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      n_q      <= '0;
      ch_q     <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      phase_q  <= 2'd0;
      start_q  <= 2'b00;
      cu_rst_q <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      n_q      <= n_d;
      ch_q     <= ch_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      phase_q  <= phase_d;
      start_q  <= start_d;
      cu_rst_q <= cu_rst_d;
      req_q    <= req_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    n_d      = n_q;
    ch_d     = ch_q;
    err_d    = err_q;
    busy_d   = busy_q;
    phase_d  = phase_q;
    start_d  = 2'b00;
    cu_rst_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        num_d   = num_ch;
        n_d     = n_in;
        ch_d    = '0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = (num_ch == '0) ? FINISH : STYLE;
      end
      STYLE:   if (style_ack) state_d = S_ISSUE;
      S_ISSUE: begin
        start_d = START_STATS;
        phase_d = 2'd1;
        state_d = S_ARM;
      end
      // The CU still shows its previous done code here; it clears once it leaves IDLE.
      S_ARM:   state_d = S_WAIT;
      S_WAIT:  if (cu_idle && cu_done == DONE_STATS) state_d = N_ISSUE;
      N_ISSUE: begin
        start_d = START_NORM;
        phase_d = 2'd2;
        state_d = N_ARM;
      end
      N_ARM:   state_d = N_WAIT;
      N_WAIT:  if (cu_idle && cu_done == DONE_NORM) state_d = NEXT;
      NEXT: begin
        if (ch_q == num_q - CW'(1)) begin
          state_d = FINISH;
        end else begin
          ch_d    = ch_q + CW'(1);
          phase_d = 2'd0;
          state_d = STYLE;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        phase_d = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wd_tmo) begin
      state_d  = FINISH;
      err_d    = 1'b1;
      cu_rst_d = 1'b1;
    end
    wd_d  = (!wd_run || state_d != state_q) ? '0 : wd_q + TO_W'(1);
    // Request tracks the state being entered so it rises the cycle after go/NEXT.
    req_d = (state_d == STYLE);
  end

  assign cu_start  = start_q;
  assign cu_N      = n_q;
  assign cu_rst    = cu_rst_q;
  assign style_req = req_q;
  assign ch_idx    = ch_q;
  assign phase     = phase_q;
  assign busy      = busy_q;
  assign job_done  = done_q;
  assign err       = err_q;

endmodule
